regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 148 ++++++++++++++
 tb/tb_regfile_mp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

    localparam int unsigned REG_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;
    localparam int unsigned NUM_WR_DEF = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set by an issue, cleared by any write to that
// address, with set taking priority when both land in the same cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_iss_valid,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    input  logic [NUM_WR-1:0]        i_wen,
    input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
    output logic [2**ADDR_W-1:0]     o_busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_iss_valid) begin
            w_set[i_iss_addr] = 1'b1;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (i_wen[p]) begin
                w_clr[i_waddr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else if (i_clr) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with zeroing sweep, write bypass on reads,
// issue scoreboard and a sticky same-address write conflict flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF,
    parameter int unsigned NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wen,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*REG_W-1:0]  wdata,
    input  logic [NUM_RD-1:0]        ren,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*REG_W-1:0]  rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_req,
    output logic                     init_done,
    output logic                     err_conflict
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_err;
    logic [REG_W-1:0]  r_regs [DEPTH];

    logic              w_ready;
    logic [NUM_WR-1:0] w_wen;
    logic              w_conflict;
    logic [DEPTH-1:0]  w_busy;
    logic [ADDR_W-1:0] w_ra;
    logic [REG_W-1:0]  w_val;
    logic              w_hit;

    assign w_ready = (r_state == ST_READY);

    // Writes only count in READY and never to register 0.
    always_comb begin
        w_wen = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_wen[p] = w_ready && wen[p] && (waddr[p*ADDR_W +: ADDR_W] != '0);
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (w_wen[p] && w_wen[q] &&
                    (waddr[p*ADDR_W +: ADDR_W] == waddr[q*ADDR_W +: ADDR_W])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Control FSM: sweep from address 1 up to DEPTH-1, then serve traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= ADDR_W'(1);
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= ADDR_W'(1);
                        r_err   <= 1'b0;
                    end else if (w_conflict) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    // Storage has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wen[p]) begin
                    r_regs[waddr[p*ADDR_W +: ADDR_W]] <= wdata[p*REG_W +: REG_W];
                end
            end
        end
    end

    // Combinational reads; the last matching write port overrides the array.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        w_ra  = '0;
        w_val = '0;
        w_hit = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra  = raddr[k*ADDR_W +: ADDR_W];
            w_val = '0;
            w_hit = 1'b0;
            if (w_ready && ren[k] && (w_ra != '0)) begin
                w_val = r_regs[w_ra];
                for (int p = 0; p < NUM_WR; p++) begin
                    if (w_wen[p] && (waddr[p*ADDR_W +: ADDR_W] == w_ra)) begin
                        w_hit = 1'b1;
                        w_val = wdata[p*REG_W +: REG_W];
                    end
                end
                rdata[k*REG_W +: REG_W] = w_val;
                rbusy[k] = w_busy[w_ra] && !w_hit;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_ready && clr_req),
        .i_iss_valid (w_ready && iss_valid && (iss_addr != '0)),
        .i_iss_addr  (iss_addr),
        .i_wen       (w_wen),
        .i_waddr     (waddr),
        .o_busy      (w_busy)
    );

    assign init_done    = w_ready;
    assign err_conflict = r_err;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: per-cycle expectations from a behavioural
// model are queued by the driver and checked by an independent monitor.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wen = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  ren = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic        clr_req = 1'b0;
    logic        init_done;
    logic        err_conflict;

    regfile_mp dut (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .ren          (ren),
        .raddr        (raddr),
        .rdata        (rdata),
        .rbusy        (rbusy),
        .iss_valid    (iss_valid),
        .iss_addr     (iss_addr),
        .clr_req      (clr_req),
        .init_done    (init_done),
        .err_conflict (err_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  rbusy;
        logic        init;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rst_drv  = 1'b0;

    // Reference model: architectural register values, busy set, sweep countdown.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ready;
    bit          m_err;
    int          m_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_left  = 31;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic cyc(input bit w0, input int a0, input logic [31:0] d0,
                       input bit w1, input int a1, input logic [31:0] d1,
                       input bit r0, input int b0, input bit r1, input int b1,
                       input bit iv, input int ia, input bit clr);
        bit          we [2];
        int          wa [2];
        logic [31:0] wd [2];
        bit          re [2];
        int          ra [2];
        exp_t        e;
        logic [31:0] v;
        bit          hit;
        @(posedge clk);
        #1;
        we[0] = w0; wa[0] = a0 % 32; wd[0] = d0;
        we[1] = w1; wa[1] = a1 % 32; wd[1] = d1;
        re[0] = r0; ra[0] = b0 % 32;
        re[1] = r1; ra[1] = b1 % 32;
        rst       = rst_drv;
        wen       = {w1, w0};
        waddr     = {5'(wa[1]), 5'(wa[0])};
        wdata     = {d1, d0};
        ren       = {r1, r0};
        raddr     = {5'(ra[1]), 5'(ra[0])};
        iss_valid = iv;
        iss_addr  = 5'(ia % 32);
        clr_req   = clr;
        if (!rst_drv) model_reset();
        // Expected outputs for this cycle, from pre-edge model state.
        e.rdata = '0;
        e.rbusy = '0;
        e.init  = m_ready;
        e.err   = m_err;
        for (int k = 0; k < 2; k++) begin
            if (m_ready && re[k] && ra[k] != 0) begin
                v   = m_regs[ra[k]];
                hit = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (we[p] && wa[p] == ra[k]) begin
                        v   = wd[p];
                        hit = 1'b1;
                    end
                end
                e.rdata[k*32 +: 32] = v;
                e.rbusy[k] = m_busy[ra[k]] && !hit;
            end
        end
        sb_q.push_back(e);
        // Advance model to post-edge state.
        if (rst_drv) begin
            if (!m_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < 32; i++) m_regs[i] = '0;
                end
            end else if (clr) begin
                model_reset();
            end else begin
                if (we[0] && we[1] && wa[0] == wa[1] && wa[0] != 0) m_err = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (we[p] && wa[p] != 0) begin
                        m_regs[wa[p]] = wd[p];
                        m_busy[wa[p]] = 1'b0;
                    end
                end
                if (iv && (ia % 32) != 0) m_busy[ia % 32] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cyc(input bit allow_clr);
        cyc($urandom_range(0, 1), $urandom_range(0, 9), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 9), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 9),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9),
            allow_clr && ($urandom_range(0, 63) == 0));
    endtask

    // Sweep length measured from the first cycle with reset released.
    task automatic measure_sweep(input string name);
        int n;
        n = 0;
        rst_drv = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, $urandom_range(1, 31), 1, $urandom_range(1, 31), 0, 0, 0);
            #3;
            if (init_done) break;
            n++;
        end
        check(name, 64'(n), 64'd31);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rdata", rdata, e.rdata);
            check("rbusy", 64'(rbusy), 64'(e.rbusy));
            check("init_done", 64'(init_done), 64'(e.init));
            check("err_conflict", 64'(err_conflict), 64'(e.err));
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = $urandom;
        model_reset();
        rst_drv = 1'b0;
        repeat (3) idle();
        measure_sweep("sweep_after_reset");

        // Bypass then registered read of r5.
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        #3 check("bypass_r5", 64'(rdata[63:32]), 64'h0000_0000_DEAD_BEEF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        #3 check("stored_r5", 64'(rdata[63:32]), 64'h0000_0000_DEAD_BEEF);

        // Two ports to r7: port 1 wins, conflict flag sticks.
        cyc(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        #3 check("conflict_r7", 64'(rdata[31:0]), 64'h22);
        check("err_set", 64'(err_conflict), 64'd1);

        // Issue r3, read busy, write+reissue same cycle keeps it busy.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        #3 check("busy_r3", 64'(rbusy[0]), 64'd1);
        cyc(1, 3, 32'h5, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        #3 check("busy_r3_set_wins", 64'(rbusy[0]), 64'd1);

        // r0 stays zero; then a clear sweep.
        cyc(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #3 check("r0_zero", 64'(rdata[31:0]), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        #3 check("clr_init_drop", 64'(init_done), 64'd0);
        check("clr_err", 64'(err_conflict), 64'd0);
        repeat (30) idle();
        for (int a = 0; a < 32; a += 2) cyc(0, 0, 0, 0, 0, 0, 1, a, 1, a + 1, 0, 0, 0);

        // Populate, clear, reset at sweep address 10, re-measure.
        repeat (20) rand_cyc(1'b0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (9) idle();
        rst_drv = 1'b0;
        repeat (2) idle();
        measure_sweep("sweep_after_midreset");

        repeat (600) rand_cyc(1'b1);
        for (int a = 0; a < 32; a += 2) cyc(0, 0, 0, 0, 0, 0, 1, a, 1, a + 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        check("queue_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
